codec_packet_framer: RTL
========================

CODEC_PACKET_FRAMER -- requirements
Module: codec_packet_framer

Interface
REQ-001 Parameter DATA_W, default 8, byte/sample width of stream (u-law encoder output).
REQ-002 Parameter PKT_LEN, default 16, beats per packet delivered to BCH encoder; SHALL be >= 2.
REQ-003 Parameter FIFO_DEPTH, default 32, input buffer entries; SHALL be a power of 2, >= 2.
REQ-004 Parameter PAD_VALUE, default 0, DATA_W-bit filler used when flushing a partial packet.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_data  in  DATA_W  input beat.
REQ-009 in_ready  out  1  framer can accept a beat.
REQ-010 flush  in  1  single-cycle request to close current partial packet with padding.
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream (BCH encoder) ready.
REQ-013 out_data  out  DATA_W  output beat.
REQ-014 out_sop / out_eop  out  1 each  first / last beat of packet.
REQ-015 fill_level  out  clog2(FIFO_DEPTH)+1  entries currently buffered.
REQ-016 overflow  out  1  sticky: beat offered while in_ready=0.
REQ-017 pkt_count  out  16  packets completed (see Configuration).

Function
REQ-018 in_ready SHALL equal (fill_level != FIFO_DEPTH); write occurs when in_valid && in_ready; a same-cycle read SHALL NOT unblock a write when full.
REQ-019 Write-to-output latency SHALL be 1 cycle: beat written into empty framer at cycle N is on out_data with out_valid=1 at cycle N+1.
REQ-020 Output transfer occurs when out_valid && out_ready; out_data/out_sop/out_eop SHALL hold stable while out_valid && !out_ready.
REQ-021 Beat index idx (0..PKT_LEN-1) SHALL advance on each transfer and wrap to 0 after the eop beat; out_sop = (idx==0), out_eop = (idx==PKT_LEN-1), both qualified by out_valid.
REQ-022 FSM states STREAM and PAD; reset state STREAM.
REQ-023 STREAM: out_valid = FIFO non-empty; out_data = FIFO head.
REQ-024 flush SHALL set pad_pending; if idx==0 and FIFO empty in that cycle, pad_pending SHALL clear with no output effect.
REQ-025 STREAM->PAD when pad_pending, FIFO empty, and idx!=0.
REQ-026 PAD: out_valid=1, out_data=PAD_VALUE; on the eop transfer go to STREAM and clear pad_pending.
REQ-027 Writes SHALL continue during PAD; those beats start the next packet (sop).
REQ-028 flush asserted during PAD or while pad_pending already set SHALL be ignored.
REQ-029 overflow SHALL set when in_valid && !in_ready and remain set until reset.
REQ-030 Simultaneous write and transfer with FIFO not full SHALL leave fill_level unchanged.

Reset
REQ-031 Reset SHALL clear FIFO pointers, idx, pad_pending, overflow, pkt_count; state=STREAM.
REQ-032 During/after reset: out_valid=0, out_sop=0, out_eop=0, out_data=0, fill_level=0, in_ready=0 while reset asserted, 1 after deassertion.
REQ-033 Reset mid-packet SHALL discard buffered beats; first beat after reset SHALL carry out_sop=1.

Configuration
REQ-034 Macro CODEC_PACKET_FRAMER_STATS_EN: when defined, pkt_count increments (wrapping at 65535->0) on every eop transfer, including padded packets; when undefined, pkt_count SHALL be constant 0 and no counter logic synthesised.

Verification (PKT_LEN=4, FIFO_DEPTH=8, PAD_VALUE=8'hFF)
REQ-035 Write 8'h01..8'h08, out_ready=1 -> two packets; sop on 01 and 05, eop on 04 and 08; pkt_count=2 with macro, 0 without.
REQ-036 Write 01,02, then flush pulse -> output 01,02,FF,FF; eop on second FF; state returns STREAM.
REQ-037 out_ready=0, write 9 beats -> in_ready=0 after 8, fill_level=8, overflow=1; out_data=01 held stable.
REQ-038 Flush with idx==0 and FIFO empty -> no output beat, pad_pending clears.
REQ-039 Reset asserted after 2 of 4 beats transferred -> outputs cleared; next write 8'hAA emerges with out_sop=1.
REQ-040 out_ready toggling 1/0 each cycle during 12-beat stream -> data order preserved, sop/eop positions unchanged.

Source files
------------

// File: rtl/codec_packet_framer.sv
// codec_packet_framer: buffers codec samples and frames them into PKT_LEN-beat packets, padding on flush.
// Define CODEC_PACKET_FRAMER_STATS_EN to count completed packets on pkt_count.
module codec_packet_framer #(
  parameter int DATA_W = 8,
  parameter int PKT_LEN = 16,
  parameter int FIFO_DEPTH = 32,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic [15:0]                   pkt_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(PKT_LEN);
  typedef enum logic {STREAM, PAD} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic pad_pending, pad_pending_d, empty, wr, rd, xfer, eop;
  assign fill_level = wr_ptr - rd_ptr;
  assign empty = fill_level == '0;
  assign in_ready = !reset && fill_level != (AW+1)'(FIFO_DEPTH);
  assign wr = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign eop = idx == IW'(PKT_LEN - 1);
  assign rd = xfer && state == STREAM;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= STREAM;
    else state <= state_d;
  always_comb
    state_d = state == STREAM ? ((pad_pending && empty && idx != '0) ? PAD : STREAM)
                              : ((xfer && eop) ? STREAM : PAD);
  always_comb begin
    out_valid = state == PAD || !empty;
    out_data = state == PAD ? PAD_VALUE : (out_valid ? mem[rd_ptr[AW-1:0]] : '0);
    out_sop = out_valid && idx == '0;
    out_eop = out_valid && eop;
  end
  // A request landing on a packet boundary with nothing buffered needs no padding.
  assign pad_pending_d = state == PAD ? !(xfer && eop)
                                      : (pad_pending || flush) && !(idx == '0 && empty);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx <= '0;
      pad_pending <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr);
      rd_ptr <= rd_ptr + (AW+1)'(rd);
      idx <= xfer ? (eop ? '0 : idx + IW'(1)) : idx;
      pad_pending <= pad_pending_d;
      overflow <= overflow || (in_valid && !in_ready);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= in_data;
`ifdef CODEC_PACKET_FRAMER_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) pkt_count <= '0;
    else if (xfer && eop) pkt_count <= pkt_count + 16'd1;
`else
  assign pkt_count = '0;
`endif
endmodule
